// File: rtl/dut.sv
// -----------------------------------------------------------------------------
// dut : registered data inverter with change detect and saturating counter
//
// On every rising clk edge the module samples data_in. It registers the
// bitwise inversion of the sample, flags whether the sample differs from the
// previous one, and advances a saturating sample counter. All outputs come
// straight from flops, so there is no combinational path from data_in to any
// output.
//
// Optional feature macro: DUT_PARITY_EN
//   When defined, the data_parity port exists. It carries the registered
//   even-parity bit of data_out, which is coherent with data_out every cycle.
//
// Parameters
//   DATA_WIDTH   : width of data_in / data_out (default 8)
//   CNT_WIDTH    : width of sample_count (default 16)
//
// Ports
//   clk          : in  : single clock, rising edge active
//   reset        : in  : synchronous active-low reset
//   data_in      : in  : data word sampled every clock
//   data_out     : out : registered ~data_in (one clock latency)
//   changed      : out : registered flag, sample differs from previous sample
//   sample_count : out : saturating count of edges since reset release
//   data_parity  : out : (DUT_PARITY_EN only) even parity of data_out
// -----------------------------------------------------------------------------
module dut #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  changed,
   output logic [CNT_WIDTH-1:0]  sample_count
`ifdef DUT_PARITY_EN
   ,
   output logic                  data_parity
`endif
);

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   // XOR reduction: set when the word has an odd number of ones, so the
   // word plus this bit always carries an even count of ones.
   function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
      return ^word;
   endfunction

   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [DATA_WIDTH-1:0] prev_in_q,  prev_in_d;
   logic                  changed_q,  changed_d;
   logic [CNT_WIDTH-1:0]  count_q,    count_d;
`ifdef DUT_PARITY_EN
   logic                  parity_q,   parity_d;
`endif

   // Next-state computation for the datapath, change flag and counter.
   always_comb begin
      data_out_d = DATA_ZERO;
      prev_in_d  = DATA_ZERO;
      changed_d  = 1'b0;
      count_d    = CNT_ZERO;

      data_out_d = ~data_in;
      prev_in_d  = data_in;
      // prev_in_q is zero right after reset, so the first sample compares to 0.
      changed_d  = (data_in != prev_in_q);
      // Counter holds at all-ones instead of wrapping.
      if (count_q == CNT_MAX) begin
         count_d = count_q;
      end else begin
         count_d = count_q + CNT_ONE;
      end
   end

`ifdef DUT_PARITY_EN
   // Parity is taken from the next data_out value so both land on the same edge.
   always_comb begin
      parity_d = 1'b0;
      parity_d = even_parity(data_out_d);
   end
`endif

   // State registers with synchronous active-low reset overriding any update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_out_q <= DATA_ZERO;
         prev_in_q  <= DATA_ZERO;
         changed_q  <= 1'b0;
         count_q    <= CNT_ZERO;
`ifdef DUT_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         data_out_q <= data_out_d;
         prev_in_q  <= prev_in_d;
         changed_q  <= changed_d;
         count_q    <= count_d;
`ifdef DUT_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign data_out     = data_out_q;
   assign changed      = changed_q;
   assign sample_count = count_q;
`ifdef DUT_PARITY_EN
   assign data_parity  = parity_q;
`endif

endmodule

// File: tb/tb_dut.sv
// -----------------------------------------------------------------------------
// tb_dut : self-checking bench for dut
//
// u_dut  : default parameters, driven from a table of per-edge vectors with
//          hand-computed expected outputs, plus a between-edge reset glitch.
// u_dut4 : CNT_WIDTH = 4, used to check counter saturation.
// -----------------------------------------------------------------------------
module tb_dut;

   typedef struct {
      logic        rst;
      logic [7:0]  din;
      logic [7:0]  exp_out;
      logic        exp_chg;
      logic [15:0] exp_cnt;
      logic        exp_par;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        changed;
   logic [15:0] sample_count;
   logic        data_parity;

   logic        reset4;
   logic [7:0]  data_in4;
   logic [7:0]  data_out4;
   logic        changed4;
   logic [3:0]  sample_count4;
   logic        data_parity4;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[13];

   dut #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_out     (data_out),
      .changed      (changed),
      .sample_count (sample_count)
`ifdef DUT_PARITY_EN
      ,
      .data_parity  (data_parity)
`endif
   );

   dut #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
      .clk          (clk),
      .reset        (reset4),
      .data_in      (data_in4),
      .data_out     (data_out4),
      .changed      (changed4),
      .sample_count (sample_count4)
`ifdef DUT_PARITY_EN
      ,
      .data_parity  (data_parity4)
`endif
   );

`ifndef DUT_PARITY_EN
   assign data_parity  = 1'b0;
   assign data_parity4 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive inputs away from the active edge, then sample 1ns after it.
   task automatic step(input logic rst, input logic [7:0] din);
      @(negedge clk);
      reset   = rst;
      data_in = din;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      data_in  = 8'h00;
      reset4   = 1'b0;
      data_in4 = 8'h00;

      //          rst   din    out    chg   cnt       par
      vecs[0]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 16'd0, 1'b0};
      vecs[1]  = '{1'b0, 8'hA5, 8'h00, 1'b0, 16'd0, 1'b0};
      vecs[2]  = '{1'b1, 8'hA5, 8'h5A, 1'b1, 16'd1, 1'b0};
      vecs[3]  = '{1'b1, 8'h5A, 8'hA5, 1'b1, 16'd2, 1'b0};
      vecs[4]  = '{1'b1, 8'h3C, 8'hC3, 1'b1, 16'd3, 1'b0};
      vecs[5]  = '{1'b1, 8'h3C, 8'hC3, 1'b0, 16'd4, 1'b0};
      vecs[6]  = '{1'b1, 8'h3C, 8'hC3, 1'b0, 16'd5, 1'b0};
      vecs[7]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 16'd6, 1'b0};
      vecs[8]  = '{1'b1, 8'hFF, 8'h00, 1'b1, 16'd7, 1'b0};
      vecs[9]  = '{1'b1, 8'h01, 8'hFE, 1'b1, 16'd8, 1'b1};
      vecs[10] = '{1'b0, 8'h77, 8'h00, 1'b0, 16'd0, 1'b0};
      vecs[11] = '{1'b1, 8'h77, 8'h88, 1'b1, 16'd1, 1'b0};
      vecs[12] = '{1'b1, 8'h77, 8'h88, 1'b0, 16'd2, 1'b0};

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].din);
         check($sformatf("v%0d data_out", i), {24'd0, data_out}, {24'd0, vecs[i].exp_out});
         check($sformatf("v%0d changed", i), {31'd0, changed}, {31'd0, vecs[i].exp_chg});
         check($sformatf("v%0d sample_count", i), {16'd0, sample_count}, {16'd0, vecs[i].exp_cnt});
`ifdef DUT_PARITY_EN
         check($sformatf("v%0d data_parity", i), {31'd0, data_parity}, {31'd0, vecs[i].exp_par});
`endif
      end

      // Reset pulse entirely between edges must be ignored.
      @(negedge clk);
      data_in = 8'h77;
      reset   = 1'b0;
      #1;
      reset   = 1'b1;
      @(posedge clk);
      #1;
      check("glitch data_out", {24'd0, data_out}, {24'd0, 8'h88});
      check("glitch changed", {31'd0, changed}, {31'd0, 1'b0});
      check("glitch sample_count", {16'd0, sample_count}, {16'd0, 16'd3});

      // Saturation on the 4-bit counter instance.
      @(negedge clk);
      reset4 = 1'b0;
      @(posedge clk);
      #1;
      check("sat reset count", {28'd0, sample_count4}, {28'd0, 4'd0});
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         reset4   = 1'b1;
         data_in4 = 8'(e);
         @(posedge clk);
         #1;
         check($sformatf("sat edge%0d count", e), {28'd0, sample_count4},
               (e >= 15) ? 32'd15 : 32'(e));
         check($sformatf("sat edge%0d data_out", e), {24'd0, data_out4}, {24'd0, ~8'(e)});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
